// File: rtl/parity_checker.sv
// Receive-side byte parity checker: per-byte mismatch flag, fixed-length frame
// pass/fail reporting, sticky error flag and saturating error counter.
module parity_checker #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data_in,
    input  logic             parity_in,
    input  logic             data_valid,
    input  logic             odd_mode,
    input  logic             clear,
    output logic [7:0]       data_out,
    output logic             out_valid,
    output logic             parity_err,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic {IDLE, RECV} state_t;

    state_t     state;
    logic       frame_mode;
    logic [7:0] byte_cnt;
    logic       frame_acc;

    logic       mode;
    logic       mismatch;
    logic [7:0] cnt_next;
    logic       last;
    logic       acc_next;

    // The first byte of a frame is checked with the live odd_mode; later bytes
    // use the mode latched at frame start.
    always_comb begin
        mode     = (state == IDLE) ? odd_mode : frame_mode;
        mismatch = parity_in != (mode ? ~^data_in : ^data_in);
        cnt_next = (state == IDLE) ? 8'd1 : byte_cnt + 8'd1;
        last     = cnt_next == 8'(FRAME_LEN);
        acc_next = ((state == RECV) && frame_acc) || mismatch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            frame_mode <= 1'b0;
            byte_cnt   <= '0;
            frame_acc  <= 1'b0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                byte_cnt   <= '0;
                frame_acc  <= 1'b0;
                err_sticky <= 1'b0;
                err_count  <= '0;
            end else if (data_valid) begin
                data_out   <= data_in;
                out_valid  <= 1'b1;
                parity_err <= mismatch;
                if (mismatch) begin
                    err_sticky <= 1'b1;
                    if (err_count != '1)
                        err_count <= err_count + CNT_W'(1);
                end
                if (state == IDLE)
                    frame_mode <= odd_mode;
                if (last) begin
                    frame_done <= 1'b1;
                    frame_ok   <= ~acc_next;
                    byte_cnt   <= '0;
                    frame_acc  <= 1'b0;
                    state      <= IDLE;
                end else begin
                    byte_cnt   <= cnt_next;
                    frame_acc  <= acc_next;
                    state      <= RECV;
                end
            end
        end
    end

endmodule

// File: tb/tb_parity_checker.sv
// Scoreboard bench for parity_checker: instance 0 uses 4-byte frames with an
// 8-bit counter, instance 1 uses 1-byte frames with a 2-bit saturating counter.
module tb_parity_checker;

    typedef struct {
        logic [7:0] data;
        bit         perr;
        bit         fdone;
        bit         fok;
        bit         sticky;
        int         cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din [2];
    logic       pin [2];
    logic       vin [2];
    logic       oin [2];
    logic       cin [2];
    logic [7:0] dout [2];
    logic       ov [2];
    logic       pe [2];
    logic       fd [2];
    logic       fok [2];
    logic       es [2];
    logic [7:0] ec0;
    logic [1:0] ec1;

    int total = 0;
    int bad = 0;

    exp_t q0[$];
    exp_t q1[$];

    // reference model state, one slot per instance
    int flen [2] = '{4, 1};
    int cmax [2] = '{255, 3};
    int nb [2];
    bit ferr [2];
    bit fm [2];
    int errs [2];
    bit stk [2];

    always #5 clk = ~clk;

    parity_checker #(.FRAME_LEN(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(din[0]), .parity_in(pin[0]),
        .data_valid(vin[0]), .odd_mode(oin[0]), .clear(cin[0]),
        .data_out(dout[0]), .out_valid(ov[0]), .parity_err(pe[0]),
        .frame_done(fd[0]), .frame_ok(fok[0]), .err_sticky(es[0]),
        .err_count(ec0)
    );

    parity_checker #(.FRAME_LEN(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(din[1]), .parity_in(pin[1]),
        .data_valid(vin[1]), .odd_mode(oin[1]), .clear(cin[1]),
        .data_out(dout[1]), .out_valid(ov[1]), .parity_err(pe[1]),
        .frame_done(fd[1]), .frame_ok(fok[1]), .err_sticky(es[1]),
        .err_count(ec1)
    );

    function automatic void chk(input string name, input int inst, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
        end
    endfunction

    function automatic int ecnt(input int i);
        return (i == 0) ? int'(ec0) : int'(ec1);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            nb[i] = 0; ferr[i] = 0; fm[i] = 0; errs[i] = 0; stk[i] = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    // Drive one instance's inputs for the coming edge and predict its response.
    task automatic put(input int i, input logic [7:0] dd, input logic pp,
                       input logic vv, input logic oo, input logic cc);
        exp_t e;
        bit mis;
        din[i] = dd; pin[i] = pp; vin[i] = vv; oin[i] = oo; cin[i] = cc;
        if (cc) begin
            nb[i] = 0; ferr[i] = 0; errs[i] = 0; stk[i] = 0;
        end else if (vv) begin
            if (nb[i] == 0) fm[i] = oo;
            // total ones (data + parity) must be even in even mode, odd in odd mode
            mis = ((($countones(dd) + int'(pp)) % 2) != int'(fm[i]));
            nb[i]++;
            ferr[i] = ferr[i] | mis;
            if (mis) begin errs[i]++; stk[i] = 1; end
            e.data   = dd;
            e.perr   = mis;
            e.fdone  = (nb[i] == flen[i]);
            e.fok    = e.fdone && !ferr[i];
            e.sticky = stk[i];
            e.cnt    = (errs[i] > cmax[i]) ? cmax[i] : errs[i];
            if (e.fdone) begin nb[i] = 0; ferr[i] = 0; end
            if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin vin[i] = 0; cin[i] = 0; end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_dout"}, i, int'(dout[i]), 0);
            chk({tag, "_ov"}, i, int'(ov[i]), 0);
            chk({tag, "_pe"}, i, int'(pe[i]), 0);
            chk({tag, "_fd"}, i, int'(fd[i]), 0);
            chk({tag, "_fok"}, i, int'(fok[i]), 0);
            chk({tag, "_sticky"}, i, int'(es[i]), 0);
            chk({tag, "_cnt"}, i, ecnt(i), 0);
        end
    endtask

    // Monitor: pops one expectation for every out_valid pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (ov[i]) begin
                    exp_t e;
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        chk("unexpected_out_valid", i, 1, 0);
                    end else begin
                        if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
                        chk("data_out", i, int'(dout[i]), int'(e.data));
                        chk("parity_err", i, int'(pe[i]), int'(e.perr));
                        chk("frame_done", i, int'(fd[i]), int'(e.fdone));
                        chk("frame_ok", i, int'(fok[i]), int'(e.fok));
                        chk("err_sticky", i, int'(es[i]), int'(e.sticky));
                        chk("err_count", i, ecnt(i), e.cnt);
                    end
                end else begin
                    chk("idle_pulses", i, int'(pe[i] | fd[i] | fok[i]), 0);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            din[i] = 0; pin[i] = 0; vin[i] = 0; oin[i] = 0; cin[i] = 0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        #2 rst_n = 1;
        tick();

        // clean even-parity frame, back-to-back
        put(0, 8'h00, 0, 1, 0, 0); tick();
        put(0, 8'h01, 1, 1, 0, 0); tick();
        put(0, 8'h03, 0, 1, 0, 0); tick();
        put(0, 8'hFF, 0, 1, 0, 0); tick();

        // error on byte 2, then a clean frame right behind it
        put(0, 8'h10, 1, 1, 0, 0); tick();
        put(0, 8'h07, 0, 1, 0, 0); tick();
        put(0, 8'h00, 0, 1, 0, 0); tick();
        put(0, 8'h00, 0, 1, 0, 0); tick();
        for (int k = 0; k < 4; k++) begin put(0, 8'h05, 0, 1, 0, 0); tick(); end

        // odd-mode frame with mode toggled mid-frame (with gaps)
        put(0, 8'h07, 0, 1, 1, 0); tick();
        put(0, 8'h00, 1, 1, 1, 0); tick();
        tick();
        put(0, 8'h01, 0, 1, 0, 0); tick();
        tick(); tick();
        put(0, 8'h03, 1, 1, 0, 0); tick();

        // saturation on the 2-bit counter, one-byte frames
        for (int k = 0; k < 5; k++) begin put(1, 8'h01, 0, 1, 0, 0); tick(); end

        // clear mid-frame drops the byte presented with it
        put(0, 8'h01, 0, 1, 0, 0); tick();
        put(0, 8'h02, 1, 1, 0, 0); tick();
        put(0, 8'h03, 1, 1, 0, 1); put(1, 8'h00, 0, 0, 0, 1); tick();
        tick();
        chk("clear_cnt", 0, ecnt(0), 0);
        chk("clear_sticky", 0, int'(es[0]), 0);
        chk("clear_cnt", 1, ecnt(1), 0);
        for (int k = 0; k < 4; k++) begin put(0, 8'h81, 0, 1, 0, 0); tick(); end

        // async reset mid-frame after an error
        put(0, 8'h0F, 0, 1, 0, 0); tick();
        put(0, 8'h01, 0, 1, 0, 0); tick();
        rst_n = 0;
        #1;
        model_reset();
        check_zero("async_reset");
        @(negedge clk);
        #2 rst_n = 1;
        tick();
        for (int k = 0; k < 4; k++) begin put(0, 8'h11, 0, 1, 0, 0); tick(); end
        tick();
        chk("post_reset_cnt", 0, ecnt(0), 0);

        // randomized traffic on both instances
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                logic [7:0] rd;
                rd = 8'($urandom);
                put(i, rd, 1'($urandom), ($urandom_range(0, 9) < 7),
                    1'($urandom), ($urandom_range(0, 49) == 0));
            end
            tick();
        end
        repeat (3) tick();
        chk("q0_drained", 0, q0.size(), 0);
        chk("q1_drained", 1, q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
